// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester-side bundle for the shared-register write arbiter
interface reg_write_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int IW = $clog2(N);

   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic [IW-1:0]  wr_src;
   logic           busy;

   modport master (output req, wdata, input gnt, q, wr_src, busy);
   modport slave  (input req, wdata, output gnt, q, wr_src, busy);
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter owning all writes to one shared register
module reg_write_arbiter #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int HOLD = 2
) (
   input  logic clk,
   input  logic reset_n,
   reg_write_arbiter_if.slave bus
);
   localparam int        IW    = $clog2(N);
   localparam int        HM1   = (HOLD > 0) ? HOLD - 1 : 0;
   localparam logic [3:0] HLAST = HM1[3:0];
   localparam logic [IW:0] NN   = N[IW:0];

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

   state_t        state, state_n;
   logic [3:0]    cnt, cnt_n;
   logic [IW-1:0] ptr, ptr_n, win;
   logic [N-1:0]  gnt_r, gnt_n;
   logic [W-1:0]  q_r;
   logic [IW-1:0] src_r;
   logic          load, found;
   logic [IW:0]   cand, nxt;

   // Search upward from ptr, wrapping modulo N; one extra bit keeps ptr+k from overflowing.
   always_comb begin
      win   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + k[IW:0];
         if (cand >= NN) cand = cand - NN;
         if (!found && bus.req[cand[IW-1:0]]) begin
            win   = cand[IW-1:0];
            found = 1'b1;
         end
      end
      nxt = {1'b0, win} + {{IW{1'b0}}, 1'b1};
      if (nxt >= NN) nxt = '0;
      ptr_n = nxt[IW-1:0];
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      gnt_n   = '0;
      unique case (state)
         S_IDLE: begin
            if (|bus.req) begin
               state_n    = S_WRITE;
               load       = 1'b1;
               gnt_n[win] = 1'b1;
            end
         end
         S_WRITE: begin
            cnt_n   = '0;
            state_n = (HOLD > 0) ? S_HOLD : S_IDLE;
         end
         S_HOLD: begin
            if (cnt == HLAST) state_n = S_IDLE;
            else              cnt_n   = cnt + 4'd1;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         ptr   <= '0;
         gnt_r <= '0;
         q_r   <= '0;
         src_r <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         gnt_r <= gnt_n;
         if (load) begin
            q_r   <= bus.wdata[win*W +: W];
            src_r <= win;
            ptr   <= ptr_n;
         end
      end
   end

   assign bus.gnt    = gnt_r;
   assign bus.q      = q_r;
   assign bus.wr_src = src_r;
   assign bus.busy   = (state != S_IDLE);
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter
module tb_reg_write_arbiter;
   localparam int N = 4, W = 8, HOLD = 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   reg_write_arbiter_if #(.N(N), .W(W)) ifc ();
   reg_write_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (.clk(clk), .reset_n(reset_n), .bus(ifc));

   typedef struct {
      int         src;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   function automatic void push_exp(int s, logic [7:0] d);
      exp_t e;
      e.src  = s;
      e.data = d;
      sb.push_back(e);
   endfunction

   task automatic wait_grant(output bit to, output int cyc);
      to  = 1'b1;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cyc++;
         if (|ifc.gnt) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic set_data(int i, logic [7:0] d);
      ifc.wdata[i*W +: W] = d;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ifc.req = 4'b1111;
      for (int i = 0; i < N; i++) set_data(i, 8'hAA);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests++; if (ifc.q !== 8'h00) begin fails++; $display("FAIL reset_q cyc%0d got %h want 00", c, ifc.q); end
         tests++; if (ifc.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt cyc%0d got %b want 0000", c, ifc.gnt); end
         tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL reset_busy cyc%0d got %b want 0", c, ifc.busy); end
         tests++; if (ifc.wr_src !== 2'd0) begin fails++; $display("FAIL reset_src cyc%0d got %0d want 0", c, ifc.wr_src); end
      end
   endtask

   task automatic test_round_robin();
      exp_t e; bit to; int cyc;
      sb.delete();
      for (int i = 0; i < N; i++) set_data(i, 8'((i + 1) * 17));
      ifc.req = 4'b1111;
      for (int i = 0; i < 5; i++) push_exp(i % N, 8'(((i % N) + 1) * 17));
      reset_n = 1'b1;
      for (int g = 0; g < 5; g++) begin
         wait_grant(to, cyc);
         tests++;
         if (to) begin fails++; $display("FAIL rr_timeout grant%0d got none want grant", g); end
         else begin
            e = sb.pop_front();
            tests++; if (ifc.gnt !== 4'(1 << e.src)) begin fails++; $display("FAIL rr_gnt grant%0d got %b want %b", g, ifc.gnt, 4'(1 << e.src)); end
            tests++; if (ifc.q !== e.data) begin fails++; $display("FAIL rr_q grant%0d got %h want %h", g, ifc.q, e.data); end
            tests++; if (ifc.wr_src !== 2'(e.src)) begin fails++; $display("FAIL rr_src grant%0d got %0d want %0d", g, ifc.wr_src, e.src); end
            if (g > 0) begin
               tests++; if (cyc !== 4) begin fails++; $display("FAIL rr_spacing grant%0d got %0d want 4", g, cyc); end
            end
         end
      end
      ifc.req = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single_write();
      exp_t e; bit to; int cyc;
      sb.delete();
      set_data(2, 8'h5A);
      ifc.req = 4'b0100;
      push_exp(2, 8'h5A);
      wait_grant(to, cyc);
      ifc.req = '0;
      tests++;
      if (to) begin fails++; $display("FAIL single_timeout got none want grant"); end
      else begin
         e = sb.pop_front();
         tests++; if (cyc !== 1) begin fails++; $display("FAIL single_latency got %0d want 1", cyc); end
         tests++; if (ifc.gnt !== 4'(1 << e.src)) begin fails++; $display("FAIL single_gnt got %b want %b", ifc.gnt, 4'(1 << e.src)); end
         tests++; if (ifc.q !== e.data) begin fails++; $display("FAIL single_q got %h want %h", ifc.q, e.data); end
         tests++; if (ifc.wr_src !== 2'(e.src)) begin fails++; $display("FAIL single_src got %0d want %0d", ifc.wr_src, e.src); end
         tests++; if (ifc.busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", ifc.busy); end
      end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         tests++; if (ifc.busy !== (c < 3)) begin fails++; $display("FAIL single_busy_tail cyc%0d got %b want %b", c, ifc.busy, (c < 3)); end
         tests++; if (ifc.gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_tail cyc%0d got %b want 0000", c, ifc.gnt); end
         tests++; if (ifc.q !== 8'h5A) begin fails++; $display("FAIL single_q_hold cyc%0d got %h want 5a", c, ifc.q); end
      end
   endtask

   task automatic test_pointer_fairness();
      exp_t e; bit to; int cyc;
      sb.delete();
      set_data(0, 8'h10);
      set_data(2, 8'h30);
      ifc.req = 4'b0101;
      push_exp(0, 8'h10);
      push_exp(2, 8'h30);
      for (int g = 0; g < 2; g++) begin
         wait_grant(to, cyc);
         ifc.req[g*2] = 1'b0;
         tests++;
         if (to) begin fails++; $display("FAIL ptr_timeout grant%0d got none want grant", g); end
         else begin
            e = sb.pop_front();
            tests++; if (ifc.gnt !== 4'(1 << e.src)) begin fails++; $display("FAIL ptr_gnt grant%0d got %b want %b", g, ifc.gnt, 4'(1 << e.src)); end
            tests++; if (ifc.q !== e.data) begin fails++; $display("FAIL ptr_q grant%0d got %h want %h", g, ifc.q, e.data); end
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ignored_requests();
      exp_t e; bit to; int cyc;
      sb.delete();
      set_data(3, 8'h77);
      set_data(1, 8'h99);
      ifc.req = 4'b1000;
      push_exp(3, 8'h77);
      wait_grant(to, cyc);
      ifc.req = '0;
      tests++;
      if (to) begin fails++; $display("FAIL ign_timeout got none want grant"); end
      else begin
         e = sb.pop_front();
         tests++; if (ifc.q !== e.data) begin fails++; $display("FAIL ign_q got %h want %h", ifc.q, e.data); end
      end
      @(negedge clk);
      ifc.req[1] = 1'b1;
      @(negedge clk);
      ifc.req[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         tests++; if (ifc.gnt !== 4'b0000) begin fails++; $display("FAIL ign_gnt cyc%0d got %b want 0000", c, ifc.gnt); end
         tests++; if (ifc.q !== 8'h77) begin fails++; $display("FAIL ign_q_hold cyc%0d got %h want 77", c, ifc.q); end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e; bit to; int cyc;
      sb.delete();
      set_data(1, 8'h42);
      ifc.req = 4'b0010;
      wait_grant(to, cyc);
      tests++;
      if (to) begin fails++; $display("FAIL mid_timeout got none want grant"); end
      reset_n = 1'b0;
      ifc.req = 4'b1111;
      for (int i = 0; i < N; i++) set_data(i, 8'(8'hA0 + i));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         tests++; if (ifc.gnt !== 4'b0000) begin fails++; $display("FAIL mid_gnt cyc%0d got %b want 0000", c, ifc.gnt); end
         tests++; if (ifc.q !== 8'h00) begin fails++; $display("FAIL mid_q cyc%0d got %h want 00", c, ifc.q); end
         tests++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL mid_busy cyc%0d got %b want 0", c, ifc.busy); end
      end
      push_exp(0, 8'hA0);
      reset_n = 1'b1;
      wait_grant(to, cyc);
      ifc.req = '0;
      tests++;
      if (to) begin fails++; $display("FAIL mid_post_timeout got none want grant"); end
      else begin
         e = sb.pop_front();
         tests++; if (cyc !== 1) begin fails++; $display("FAIL mid_post_latency got %0d want 1", cyc); end
         tests++; if (ifc.gnt !== 4'(1 << e.src)) begin fails++; $display("FAIL mid_post_gnt got %b want %b", ifc.gnt, 4'(1 << e.src)); end
         tests++; if (ifc.q !== e.data) begin fails++; $display("FAIL mid_post_q got %h want %h", ifc.q, e.data); end
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      ifc.req   = '0;
      ifc.wdata = '0;
      reset_n   = 1'b0;
      test_reset();
      test_round_robin();
      test_single_write();
      test_pointer_fairness();
      test_ignored_requests();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end
endmodule
